// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit field layout, header pack/extract helpers and clog2
package noc_pkg;

    // Headers are handled as a fixed 32-bit word; X_SIZE+Y_SIZE must stay at or below 31.
    localparam int HDR_MAX = 32;
    typedef logic [HDR_MAX-1:0] hdr_t;

    // Flit layout: dest x at the bottom, dest y above it, payload on top.
    localparam int X_LSB = 0;

    function automatic int y_lsb(input int x_size);
        return x_size;
    endfunction

    function automatic int payload_lsb(input int x_size, input int y_size);
        return x_size + y_size;
    endfunction

    function automatic hdr_t hdr_pack(input int x_size, input hdr_t x, input hdr_t y);
        return (y << x_size) | x;
    endfunction

    function automatic hdr_t hdr_get_x(input int x_size, input hdr_t hdr);
        return (hdr >> X_LSB) & ((hdr_t'(1) << x_size) - hdr_t'(1));
    endfunction

    function automatic hdr_t hdr_get_y(input int x_size, input int y_size, input hdr_t hdr);
        return (hdr >> y_lsb(x_size)) & ((hdr_t'(1) << y_size) - hdr_t'(1));
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_ni_fifo.sv
// rtl/noc_ni_fifo.sv - synchronous FIFO with full/empty/count, push+pop allowed when full
module noc_ni_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    output logic                    full,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok, pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointers and occupancy; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/noc_pe_ni.sv
// rtl/noc_pe_ni.sv - PE-side NoC network interface; NOC_NI_STATS_EN adds flit/drop counters
module noc_pe_ni
    import noc_pkg::*;
#(
    parameter int X_COORD     = 0,
    parameter int Y_COORD     = 0,
    parameter int DATA_WIDTH  = 32,
    parameter int X_SIZE      = 1,
    parameter int Y_SIZE      = 1,
    parameter int TOTAL_WIDTH = X_SIZE + Y_SIZE + DATA_WIDTH,
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic [X_SIZE-1:0]      s_dest_x,
    input  logic [Y_SIZE-1:0]      s_dest_y,
    output logic                   sw_valid_o,
    input  logic                   sw_ready_i,
    output logic [TOTAL_WIDTH-1:0] sw_data_o,
    input  logic                   sw_valid_i,
    input  logic [TOTAL_WIDTH-1:0] sw_data_i,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   rx_overflow,
    output logic                   rx_misroute
`ifdef NOC_NI_STATS_EN
    ,
    output logic [31:0]            tx_flit_count,
    output logic [31:0]            rx_flit_count,
    output logic [31:0]            rx_drop_count
`endif
);

    localparam int PLD_LSB = payload_lsb(X_SIZE, Y_SIZE);

    logic                       tx_push, tx_pop, tx_full, tx_empty;
    logic [TOTAL_WIDTH-1:0]     tx_flit;
    logic [clog2(TX_DEPTH):0]   tx_count;
    logic                       rx_push, rx_pop, rx_full, rx_empty, rx_drop, rx_bad;
    logic [clog2(RX_DEPTH):0]   rx_count;
    logic [DATA_WIDTH-1:0]      rx_payload;
    hdr_t                       tx_hdr, rx_hdr;
    logic                       overflow_q, overflow_d;
    logic                       misroute_q, misroute_d;
    logic                       unused_counts;

    // Occupancy counts are kept for debug visibility only.
    assign unused_counts = ^{tx_count, rx_count};

    // TX side: build the flit and handshake with PE and switch; valid never looks at ready.
    always_comb begin
        tx_hdr     = hdr_pack(X_SIZE, hdr_t'(s_dest_x), hdr_t'(s_dest_y));
        tx_flit    = {s_data, tx_hdr[PLD_LSB-1:0]};
        s_ready    = rstn && !tx_full;
        tx_push    = s_valid && s_ready;
        sw_valid_o = !tx_empty;
        tx_pop     = sw_valid_o && sw_ready_i;
    end

    // RX side: every offered flit is taken or dropped this cycle; header checked against our node.
    always_comb begin
        m_valid    = !rx_empty;
        rx_pop     = m_valid && m_ready;
        rx_push    = sw_valid_i && (!rx_full || rx_pop);
        rx_drop    = sw_valid_i && rx_full && !rx_pop;
        rx_payload = sw_data_i[TOTAL_WIDTH-1:PLD_LSB];
        rx_hdr     = hdr_t'(sw_data_i[PLD_LSB-1:0]);
        rx_bad     = sw_valid_i &&
                     ((hdr_get_x(X_SIZE, rx_hdr) != hdr_t'(X_COORD)) ||
                      (hdr_get_y(X_SIZE, Y_SIZE, rx_hdr) != hdr_t'(Y_COORD)));
        overflow_d = overflow_q || rx_drop;
        misroute_d = misroute_q || rx_bad;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            overflow_q <= 1'b0;
            misroute_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            misroute_q <= misroute_d;
        end
    end

    assign rx_overflow = overflow_q;
    assign rx_misroute = misroute_q;

    noc_ni_fifo #(
        .WIDTH (TOTAL_WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (tx_push),
        .push_data (tx_flit),
        .full      (tx_full),
        .pop       (tx_pop),
        .pop_data  (sw_data_o),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    noc_ni_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rx_push),
        .push_data (rx_payload),
        .full      (rx_full),
        .pop       (rx_pop),
        .pop_data  (m_data),
        .empty     (rx_empty),
        .count     (rx_count)
    );

`ifdef NOC_NI_STATS_EN
    logic [31:0] tx_cnt_q, tx_cnt_d;
    logic [31:0] rx_cnt_q, rx_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Wrapping traffic counters.
    always_comb begin
        tx_cnt_d   = tx_cnt_q + 32'(tx_pop);
        rx_cnt_d   = rx_cnt_q + 32'(rx_push);
        drop_cnt_d = drop_cnt_q + 32'(rx_drop);
    end

    // Counter state, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign tx_flit_count = tx_cnt_q;
    assign rx_flit_count = rx_cnt_q;
    assign rx_drop_count = drop_cnt_q;
`endif

endmodule
